// File: rtl/cache_fill_arbiter.sv
// ----------------------------------------------------------------------------
// cache_fill_arbiter
//
// Purpose:
//   Arbitrates cache-line fills between an I-cache and a D-cache miss port.
//   A granted miss issues 8 word reads to memory on consecutive cycles.
//   Returning words (in issue order) are written into the granted cache.
//   After the 8th word, a single tag-write cycle completes the line. After
//   that the arbiter waits at least one idle cycle before granting again,
//   so the refreshed miss signal can settle.
//
// Build option:
//   ARB_RR_EN - when defined, simultaneous misses are granted round-robin:
//               the requester not granted last wins. When undefined, the
//               D-cache always wins ties.
//
// Ports:
//   clk                 - clock; all state changes on its rising edge
//   rst                 - asynchronous, active-low reset
//   icache_miss(_addr)  - I-cache miss request and its address
//   dcache_miss(_addr)  - D-cache miss request and its address
//   mem_data_valid      - one returned memory word this cycle
//   mem_read_en/mem_addr- memory read issue strobe and address
//   fill_addr           - word address (data) or line address (tag) for the
//                         cache being filled
//   fill_offset         - index of the returning word within the line
//   {i,d}cache_{data,tag}_write - per-cache fill strobes
//   stall               - pipeline stall request
// ----------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_miss_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_miss_addr,
    input  logic              mem_data_valid,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [2:0]        fill_offset,
    output logic              icache_data_write,
    output logic              icache_tag_write,
    output logic              dcache_data_write,
    output logic              dcache_tag_write,
    output logic              stall
);

    localparam int BASE_W = ADDR_W - 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [BASE_W-1:0]   base_reg;
    logic                gnt_icache_reg;   // 1: I-cache owns the fill
    logic [2:0]          issue_cnt_reg;
    logic                issuing_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [2:0]          ret_cnt_reg;
    logic                settle_reg;       // blocks the first idle cycle after TAG

    logic                pick_icache;
    logic [ADDR_W-1:0]   grant_addr;
    logic [2:0]          issue_cnt_next;
    logic                fill_word;

    // Line-offset bits of the miss addresses are not needed: fills are
    // always whole-line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{icache_miss_addr[3:0], dcache_miss_addr[3:0]};

`ifdef ARB_RR_EN
    logic rr_icache_reg;   // I-cache wins the next tie; reset favours dcache
    assign pick_icache = icache_miss & (~dcache_miss | rr_icache_reg);
`else
    assign pick_icache = icache_miss & ~dcache_miss;
`endif

    assign grant_addr     = pick_icache ? icache_miss_addr : dcache_miss_addr;
    assign issue_cnt_next = issue_cnt_reg + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            gnt_icache_reg <= 1'b0;
            issue_cnt_reg  <= 3'd0;
            issuing_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            ret_cnt_reg    <= 3'd0;
            settle_reg     <= 1'b0;
`ifdef ARB_RR_EN
            rr_icache_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    settle_reg <= 1'b0;
                    if (!settle_reg && (icache_miss || dcache_miss)) begin
                        state_reg      <= FILL;
                        gnt_icache_reg <= pick_icache;
                        base_reg       <= grant_addr[ADDR_W-1:4];
                        issue_cnt_reg  <= 3'd0;
                        ret_cnt_reg    <= 3'd0;
                        issuing_reg    <= 1'b1;
                        mem_addr_reg   <= {grant_addr[ADDR_W-1:4], 4'b0000};
`ifdef ARB_RR_EN
                        rr_icache_reg  <= ~pick_icache;
`endif
                    end
                end
                FILL: begin
                    if (issuing_reg) begin
                        if (issue_cnt_reg == 3'd7) begin
                            issuing_reg  <= 1'b0;
                            mem_addr_reg <= '0;
                        end else begin
                            issue_cnt_reg <= issue_cnt_next;
                            mem_addr_reg  <= {base_reg, issue_cnt_next, 1'b0};
                        end
                    end
                    if (mem_data_valid) begin
                        ret_cnt_reg <= ret_cnt_reg + 3'd1;
                        if (ret_cnt_reg == 3'd7) begin
                            state_reg    <= TAG;
                            // Returns arrive in issue order, so issuing is
                            // already over; clear anyway to keep TAG clean.
                            issuing_reg  <= 1'b0;
                            mem_addr_reg <= '0;
                        end
                    end
                end
                TAG: begin
                    state_reg  <= IDLE;
                    settle_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Data strobes follow mem_data_valid in the same cycle.
    assign fill_word = (state_reg == FILL) && mem_data_valid;

    assign icache_data_write = fill_word & gnt_icache_reg;
    assign dcache_data_write = fill_word & ~gnt_icache_reg;
    assign icache_tag_write  = (state_reg == TAG) & gnt_icache_reg;
    assign dcache_tag_write  = (state_reg == TAG) & ~gnt_icache_reg;

    always_comb begin
        fill_addr   = '0;
        fill_offset = 3'd0;
        if (fill_word) begin
            fill_addr   = {base_reg, ret_cnt_reg, 1'b0};
            fill_offset = ret_cnt_reg;
        end else if (state_reg == TAG) begin
            fill_addr   = {base_reg, 4'b0000};
        end
    end

    assign mem_read_en = issuing_reg;
    assign mem_addr    = mem_addr_reg;
    assign stall       = (state_reg != IDLE) | icache_miss | dcache_miss;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss, mem_data_valid;
    logic [15:0] icache_miss_addr, dcache_miss_addr;
    logic        mem_read_en;
    logic [15:0] mem_addr, fill_addr;
    logic [2:0]  fill_offset;
    logic        icache_data_write, icache_tag_write;
    logic        dcache_data_write, dcache_tag_write, stall;

    cache_fill_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .mem_data_valid(mem_data_valid),
        .mem_read_en(mem_read_en), .mem_addr(mem_addr),
        .fill_addr(fill_addr), .fill_offset(fill_offset),
        .icache_data_write(icache_data_write), .icache_tag_write(icache_tag_write),
        .dcache_data_write(dcache_data_write), .dcache_tag_write(dcache_tag_write),
        .stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model (cycle-number based) ----------------
    bit          m_busy = 0;
    bit          m_gi = 0;          // 1: icache granted
    logic [11:0] m_base = '0;
    int          m_gcyc = 0;        // cycle the grant was made
    int          m_rets = 0;
    int          m_tag_cyc = -1;
    int          m_allow = 0;       // first cycle a new grant is allowed
    bit          m_rr_icache = 0;

    // memory model: cycles at which issued words return
    int          ret_q[$];
    int          last_ret = 0;
    bit          drain_hold = 0;
    bit          lat_rand = 0;
    int          lat_fixed = 4;

    // observations of DUT activity, used by the literal pins
    int          obs_issues, obs_first_issue, obs_dw_i, obs_dw_d, obs_tag_cyc;
    logic [15:0] obs_first_addr, obs_last_addr, obs_tag_addr;
    int          obs_off[$];
    bit          obs_tags[$];

    always @(negedge clk) begin
        logic        e_re, e_idw, e_itw, e_ddw, e_dtw, e_stall, gi;
        logic [15:0] e_ma, e_fa, ga;
        logic [2:0]  e_fo, k3, r3;
        int          k, t, lat;
        e_re = 0; e_idw = 0; e_itw = 0; e_ddw = 0; e_dtw = 0;
        e_ma = '0; e_fa = '0; e_fo = '0;
        e_stall = icache_miss | dcache_miss | (rst & m_busy);
        if (ret_q.size() > 0 && ret_q[0] == cyc) void'(ret_q.pop_front());
        if (!rst) begin
            m_busy = 0; m_rets = 0; m_tag_cyc = -1; m_allow = 0; m_rr_icache = 0;
            if (ret_q.size() > 0) drain_hold = 1;
        end else if (!m_busy) begin
            if ((icache_miss || dcache_miss) && cyc >= m_allow) begin
                if (icache_miss && dcache_miss) gi = RR ? m_rr_icache : 1'b0;
                else gi = icache_miss;
                ga = gi ? icache_miss_addr : dcache_miss_addr;
                m_base = ga[15:4]; m_gi = gi; m_gcyc = cyc; m_rets = 0;
                m_tag_cyc = -1; m_busy = 1;
                if (RR) m_rr_icache = !gi;
            end
        end else if (cyc == m_tag_cyc) begin
            e_itw = m_gi; e_dtw = !m_gi; e_fa = {m_base, 4'b0000};
            m_busy = 0; m_allow = cyc + 2;
        end else begin
            k = cyc - m_gcyc - 1;
            if (k < 8) begin
                k3 = k[2:0];
                e_re = 1; e_ma = {m_base, k3, 1'b0};
                lat = lat_rand ? int'($urandom_range(1, 6)) : lat_fixed;
                t = cyc + lat;
                if (t <= last_ret) t = last_ret + 1;
                last_ret = t;
                ret_q.push_back(t);
            end
            if (mem_data_valid) begin
                r3 = m_rets[2:0];
                e_idw = m_gi; e_ddw = !m_gi; e_fo = r3; e_fa = {m_base, r3, 1'b0};
                m_rets++;
                if (m_rets == 8) m_tag_cyc = cyc + 1;
            end
        end
        chk("mem_read_en", mem_read_en, e_re);
        chk("mem_addr", mem_addr, e_ma);
        chk("fill_addr", fill_addr, e_fa);
        chk("fill_offset", fill_offset, e_fo);
        chk("strobes", {icache_data_write, icache_tag_write, dcache_data_write, dcache_tag_write},
            {e_idw, e_itw, e_ddw, e_dtw});
        chk("stall", stall, e_stall);

        if (mem_read_en) begin
            if (obs_issues == 0) begin obs_first_issue = cyc; obs_first_addr = mem_addr; end
            obs_last_addr = mem_addr;
            obs_issues++;
        end
        if (icache_data_write) begin obs_dw_i++; obs_off.push_back(int'(fill_offset)); end
        if (dcache_data_write) begin obs_dw_d++; obs_off.push_back(int'(fill_offset)); end
        if (icache_tag_write || dcache_tag_write) begin
            obs_tags.push_back(icache_tag_write);
            obs_tag_addr = fill_addr;
            obs_tag_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    bit rand_mode = 0;
    bit spur_en   = 0;
    int rst_hold  = 0;

    task automatic clear_obs();
        obs_issues = 0; obs_dw_i = 0; obs_dw_d = 0; obs_tag_cyc = -1;
        obs_first_issue = -1; obs_first_addr = '0; obs_last_addr = '0; obs_tag_addr = '0;
        obs_off.delete(); obs_tags.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (drain_hold && ret_q.size() == 0) drain_hold = 0;
        if (rand_mode) begin
            if (!rst) begin
                if (rst_hold > 0) rst_hold--;
                else rst = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0; rst_hold = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 3) == 0) icache_miss = ~icache_miss;
            if ($urandom_range(0, 3) == 0) dcache_miss = ~dcache_miss;
            if ($urandom_range(0, 2) == 0) icache_miss_addr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) dcache_miss_addr = 16'($urandom);
            if (drain_hold) begin icache_miss = 0; dcache_miss = 0; end
        end
        mem_data_valid = (ret_q.size() > 0 && ret_q[0] == cyc) ||
                         (spur_en && (!m_busy || m_tag_cyc == cyc) && $urandom_range(0, 3) == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; icache_miss = 0; dcache_miss = 0;
        icache_miss_addr = '0; dcache_miss_addr = '0; mem_data_valid = 0;
        clear_obs();
        run(3);
        chk("reset_stall", stall, 1'b0);
        chk("reset_read_en", mem_read_en, 1'b0);
        rst = 1'b1;

        // Stray returns in IDLE are ignored
        spur_en = 1; run(8); spur_en = 0; run(1);
        chk("idle_spur_writes", obs_dw_i + obs_dw_d, 0);
        chk("idle_spur_stall", stall, 1'b0);

        // Single D-cache fill, latency 4
        clear_obs(); lat_fixed = 4;
        dcache_miss = 1; dcache_miss_addr = 16'h1234;
        for (int i = 0; i < 60 && obs_tags.size() == 0; i++) tick();
        chk("fill1_timeout", obs_tags.size(), 1);
        dcache_miss = 0; run(3);
        chk("fill1_issues", obs_issues, 8);
        chk("fill1_first_addr", obs_first_addr, 16'h1230);
        chk("fill1_last_addr", obs_last_addr, 16'h123E);
        chk("fill1_dwrites", obs_dw_d, 8);
        chk("fill1_iwrites", obs_dw_i, 0);
        for (int i = 0; i < obs_off.size(); i++) chk("fill1_offset", obs_off[i], i);
        chk("fill1_tag_addr", obs_tag_addr, 16'h1230);
        chk("fill1_tag_delay", obs_tag_cyc - obs_first_issue, 12);

        // Simultaneous misses, two fills back to back
        clear_obs(); lat_fixed = 2;
        icache_miss = 1; icache_miss_addr = 16'h4560;
        dcache_miss = 1; dcache_miss_addr = 16'h7890;
        for (int i = 0; i < 120 && obs_tags.size() < 2; i++) tick();
        icache_miss = 0; dcache_miss = 0;
        chk("tie_timeout", obs_tags.size(), 2);
        run(3);
        if (obs_tags.size() >= 2) begin
            chk("tie_first_owner", obs_tags[0], 1'b0);
            chk("tie_second_owner", obs_tags[1], RR);
        end

        // Granted I-cache miss dropped two cycles after the grant
        clear_obs(); lat_fixed = 5;
        icache_miss = 1; icache_miss_addr = 16'hABCD;
        for (int i = 0; i < 20 && obs_issues == 0; i++) tick();
        icache_miss = 0;
        for (int i = 0; i < 60 && obs_tags.size() == 0; i++) tick();
        run(3);
        chk("drop_iwrites", obs_dw_i, 8);
        chk("drop_itag", obs_tags.size(), 1);
        chk("drop_tag_addr", obs_tag_addr, 16'hABC0);

        // Reset after the third returned word
        clear_obs(); lat_fixed = 3;
        dcache_miss = 1; dcache_miss_addr = 16'h2468;
        for (int i = 0; i < 40 && obs_dw_d < 3; i++) tick();
        rst = 1'b0; dcache_miss = 0;
        #1;
        chk("rst_mem_read_en", mem_read_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_stall", stall, 1'b0);
        run(2);
        rst = 1'b1;
        for (int i = 0; i < 40 && ret_q.size() > 0; i++) tick();
        run(3);
        chk("rst_no_tag", obs_tags.size(), 0);
        chk("rst_dwrites", obs_dw_d, 3);
        drain_hold = 0;
        clear_obs();
        dcache_miss = 1;
        for (int i = 0; i < 60 && obs_tags.size() == 0; i++) tick();
        dcache_miss = 0; run(3);
        chk("refill_dwrites", obs_dw_d, 8);
        chk("refill_first_offset", obs_off.size() > 0 ? obs_off[0] : -1, 0);
        chk("refill_tag", obs_tags.size(), 1);

        // Randomized traffic
        rand_mode = 1; spur_en = 1; lat_rand = 1;
        run(3000);
        rand_mode = 0; icache_miss = 0; dcache_miss = 0; rst = 1'b1;
        run(60);
        spur_en = 0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
